// File: rtl/issue_wb_unit_if.sv
// Handshake bundle between issue_wb_unit and its neighbours.
// Carries the instruction input channel (valid/ready) and the execute-stage
// loop (registered operands out, combinational result back).
// slave  : the issue/writeback unit side.
// master : the instruction source plus execute stage side.
//
// Ports of the bundle:
//   in_valid   instruction present            (master -> slave)
//   in_ready   unit can accept, equals !full  (slave -> master)
//   in_instr   [8:6] sel [5:4] dst [3:2] src_a [1:0] src_b
//   exec_rs    operand A to execute stage     (slave -> master)
//   exec_rt    operand B to execute stage     (slave -> master)
//   exec_sel   opcode to execute stage        (slave -> master)
//   exec_valid exec_* carry a live instruction (slave -> master)
//   exec_rd    combinational execute result   (master -> slave)
interface issue_wb_unit_if;
  logic       in_valid;
  logic       in_ready;
  logic [8:0] in_instr;
  logic [3:0] exec_rs;
  logic [3:0] exec_rt;
  logic [2:0] exec_sel;
  logic       exec_valid;
  logic [3:0] exec_rd;

  modport slave (
    input  in_valid,
    input  in_instr,
    input  exec_rd,
    output in_ready,
    output exec_rs,
    output exec_rt,
    output exec_sel,
    output exec_valid
  );

  modport master (
    output in_valid,
    output in_instr,
    output exec_rd,
    input  in_ready,
    input  exec_rs,
    input  exec_rt,
    input  exec_sel,
    input  exec_valid
  );
endinterface

// File: rtl/issue_wb_unit.sv
// Issue/writeback stage: FIFO-buffered 9-bit instructions, 4x4-bit regfile, result forwarding.
// Latency: accept at edge k, issue at k+1, writeback and retire at k+2; one instruction per cycle.
// Backpressure: in_ready = !full (no same-cycle pop credit); run=0 freezes issue only.
//
// Ports:
//   clk, rst   single clock, synchronous active-high reset
//   bus        issue_wb_unit_if.slave (instruction handshake + execute-stage loop)
//   run        issue enable; the FIFO keeps accepting while run=0
//   dbg_addr   debug register select
//   dbg_data   combinational read of reg[dbg_addr], post-writeback, unforwarded
//   retired    8-bit count of written-back instructions, wraps 255 -> 0
module issue_wb_unit #(
  parameter int          DEPTH = 4,
  parameter logic [15:0] INIT  = 16'h0000
) (
  input  logic                  clk,
  input  logic                  rst,
  issue_wb_unit_if.slave        bus,
  input  logic                  run,
  input  logic [1:0]            dbg_addr,
  output logic [3:0]            dbg_data,
  output logic [7:0]            retired
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  typedef struct packed {
    logic [2:0] sel;
    logic [1:0] dst;
    logic [1:0] src_a;
    logic [1:0] src_b;
  } instr_t;

  // ---------------------------------------------------------------------
  // Instruction FIFO. Pointers carry one extra wrap bit so that full and
  // empty are distinguishable without a separate occupancy counter.
  // ---------------------------------------------------------------------
  instr_t      fifo_mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        fifo_full;
  logic        fifo_empty;
  logic        push;
  logic        pop;
  instr_t      head;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                      (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // in_ready deliberately ignores a same-cycle pop: a full FIFO refuses the
  // push even while it is being drained, which keeps in_ready off the run path.
  assign bus.in_ready = !fifo_full;
  assign push         = bus.in_valid && !fifo_full;
  assign pop          = run && !fifo_empty;
  assign head         = fifo_mem[rd_ptr[AW-1:0]];

  // Storage needs no reset: entries are only read between the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr[AW-1:0]] <= bus.in_instr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Register file and writeback.
  // ---------------------------------------------------------------------
  logic [3:0] regs [4];
  logic [1:0] dst_q;

  // The instruction sitting in exec always retires, whether or not run is
  // high; only the reset edge cancels it.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        regs[i] <= INIT[4*i +: 4];
      end
      retired <= 8'd0;
    end else if (bus.exec_valid) begin
      regs[dst_q] <= bus.exec_rd;
      retired     <= retired + 8'd1;
    end
  end

  assign dbg_data = regs[dbg_addr];

  // ---------------------------------------------------------------------
  // Operand read with forwarding. The register being written back on this
  // edge still holds its stale value, so a source matching the in-flight
  // dst takes exec_rd directly. This mux is the exec_rd -> flop path.
  // ---------------------------------------------------------------------
  logic       fwd_a;
  logic       fwd_b;
  logic [3:0] opnd_a;
  logic [3:0] opnd_b;

  assign fwd_a  = bus.exec_valid && (head.src_a == dst_q);
  assign fwd_b  = bus.exec_valid && (head.src_b == dst_q);
  assign opnd_a = fwd_a ? bus.exec_rd : regs[head.src_a];
  assign opnd_b = fwd_b ? bus.exec_rd : regs[head.src_b];

  // ---------------------------------------------------------------------
  // Execute-stage launch registers. On a non-issue cycle the operands,
  // opcode and dst hold so the execute inputs stay quiet.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.exec_rs    <= 4'd0;
      bus.exec_rt    <= 4'd0;
      bus.exec_sel   <= 3'd0;
      bus.exec_valid <= 1'b0;
      dst_q          <= 2'd0;
    end else if (pop) begin
      bus.exec_rs    <= opnd_a;
      bus.exec_rt    <= opnd_b;
      bus.exec_sel   <= head.sel;
      bus.exec_valid <= 1'b1;
      dst_q          <= head.dst;
    end else begin
      bus.exec_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_issue_wb_unit.sv
// Bench for issue_wb_unit: directed scenarios plus randomized traffic,
// checked every cycle against a sequential-semantics reference model.
module tb_issue_wb_unit;
  localparam int          DEPTH = 4;
  localparam logic [15:0] INIT  = 16'h4321;

  logic       clk = 1'b0;
  logic       rst;
  logic       run;
  logic [1:0] dbg_addr;
  logic [3:0] dbg_data;
  logic [7:0] retired;

  issue_wb_unit_if bus();

  issue_wb_unit #(.DEPTH(DEPTH), .INIT(INIT)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .run      (run),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data),
    .retired  (retired)
  );

  always #5 clk = ~clk;

  // Execute stage: combinational 4-bit ALU, result truncated to 4 bits.
  function automatic logic [3:0] alu(input logic [2:0] s, input logic [3:0] a, input logic [3:0] b);
    case (s)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return ~a;
      3'd6: return a << 1;
      default: return b;
    endcase
  endfunction

  assign bus.exec_rd = alu(bus.exec_sel, bus.exec_rs, bus.exec_rt);

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
  endtask

  // ---------------------------------------------------------------------
  // Reference model: an in-order machine. At each edge the instruction in
  // exec completes first (architectural state updated), then the next
  // instruction reads its operands from that architectural state. This
  // makes forwarding implicit rather than modelled as a bypass.
  // ---------------------------------------------------------------------
  logic [8:0] m_q[$];
  logic [3:0] m_regs [4];
  logic       m_v;
  logic [3:0] m_rs, m_rt;
  logic [2:0] m_sel;
  logic [1:0] m_dst;
  int         m_retired;
  logic [8:0] m_h;
  bit         m_push, m_pop;

  always @(posedge clk) begin
    if (rst) begin
      m_q.delete();
      for (int i = 0; i < 4; i++) m_regs[i] = INIT[4*i +: 4];
      m_v = 1'b0; m_rs = 4'd0; m_rt = 4'd0; m_sel = 3'd0; m_dst = 2'd0;
      m_retired = 0;
    end else begin
      m_push = bus.in_valid && (m_q.size() < DEPTH);
      m_pop  = run && (m_q.size() > 0);
      if (m_v) begin
        m_regs[m_dst] = alu(m_sel, m_rs, m_rt);
        m_retired = (m_retired + 1) % 256;
      end
      if (m_pop) begin
        m_h   = m_q.pop_front();
        m_sel = m_h[8:6];
        m_dst = m_h[5:4];
        m_rs  = m_regs[m_h[3:2]];
        m_rt  = m_regs[m_h[1:0]];
        m_v   = 1'b1;
      end else begin
        m_v = 1'b0;
      end
      if (m_push) m_q.push_back(bus.in_instr);
    end
  end

  // Every-cycle comparison, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("in_ready",   32'(bus.in_ready),   32'(m_q.size() < DEPTH));
      check("exec_valid", 32'(bus.exec_valid), 32'(m_v));
      check("exec_rs",    32'(bus.exec_rs),    32'(m_rs));
      check("exec_rt",    32'(bus.exec_rt),    32'(m_rt));
      check("exec_sel",   32'(bus.exec_sel),   32'(m_sel));
      check("dbg_data",   32'(dbg_data),       32'(m_regs[dbg_addr]));
      check("retired",    32'(retired),        32'(m_retired));
    end
  end

  task automatic tick(input bit v, input logic [8:0] ins, input bit r, input logic [1:0] a);
    @(posedge clk); #1;
    bus.in_valid = v; bus.in_instr = ins; run = r; dbg_addr = a;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; bus.in_valid = 1'b0; run = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  logic [8:0] full_set [5];
  logic [8:0] ins;
  logic [5:0] r6;
  bit         accepted;
  int         n_ev, first_ev, last_ev, pushed, cyc;

  initial begin
    rst = 1'b1; run = 1'b0; dbg_addr = 2'd0;
    bus.in_valid = 1'b0; bus.in_instr = 9'd0;
    full_set[0] = 9'h006; full_set[1] = 9'h071; full_set[2] = 9'h0B9;
    full_set[3] = 9'h0E4; full_set[4] = 9'h12C;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk_en = 1'b1;

    // Reset image and reset outputs.
    for (int a = 0; a < 4; a++) begin
      tick(1'b0, 9'd0, 1'b0, 2'(a));
      @(negedge clk);
      check("init_reg", 32'(dbg_data), 32'(a + 1));
    end
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_exec_valid", 32'(bus.exec_valid), 32'd0);
    check("rst_retired", 32'(retired), 32'd0);
    check("rst_exec_ops", {20'd0, bus.exec_sel, bus.exec_rs, bus.exec_rt}, 32'd0);

    // Single add: r0 = r1 + r2 = 2 + 3.
    do_reset();
    tick(1'b1, 9'h006, 1'b1, 2'd0);
    tick(1'b0, 9'd0, 1'b1, 2'd0);
    tick(1'b0, 9'd0, 1'b1, 2'd0);
    @(negedge clk);
    check("add_valid", 32'(bus.exec_valid), 32'd1);
    check("add_rs", 32'(bus.exec_rs), 32'd2);
    check("add_rt", 32'(bus.exec_rt), 32'd3);
    tick(1'b0, 9'd0, 1'b1, 2'd0);
    @(negedge clk);
    check("add_valid_drop", 32'(bus.exec_valid), 32'd0);
    check("add_r0", 32'(dbg_data), 32'd5);
    check("add_retired", 32'(retired), 32'd1);

    // Forwarding: r0 = r1 + r2, then r3 = r0 - r1 back to back.
    do_reset();
    tick(1'b1, 9'h006, 1'b1, 2'd3);
    tick(1'b1, 9'h071, 1'b1, 2'd3);
    tick(1'b0, 9'd0, 1'b1, 2'd3);
    @(negedge clk);
    check("fwd_first_valid", 32'(bus.exec_valid), 32'd1);
    tick(1'b0, 9'd0, 1'b1, 2'd3);
    @(negedge clk);
    check("fwd_second_valid", 32'(bus.exec_valid), 32'd1);
    check("fwd_rs", 32'(bus.exec_rs), 32'd5);
    check("fwd_rt", 32'(bus.exec_rt), 32'd2);
    check("fwd_sel", 32'(bus.exec_sel), 32'd1);
    tick(1'b0, 9'd0, 1'b1, 2'd3);
    @(negedge clk);
    check("fwd_r3", 32'(dbg_data), 32'd3);
    check("fwd_retired", 32'(retired), 32'd2);
    check("fwd_model_r3", 32'(m_regs[3]), 32'd3);

    // Full FIFO with run held low, then drain.
    do_reset();
    for (int i = 0; i < 4; i++) tick(1'b1, full_set[i], 1'b0, 2'd0);
    tick(1'b1, full_set[4], 1'b0, 2'd0);
    @(negedge clk);
    check("full_ready", 32'(bus.in_ready), 32'd0);
    check("full_no_issue", 32'(bus.exec_valid), 32'd0);
    tick(1'b1, full_set[4], 1'b0, 2'd0);
    @(negedge clk);
    check("full_ready_hold", 32'(bus.in_ready), 32'd0);
    tick(1'b1, full_set[4], 1'b1, 2'd0);
    accepted = 1'b0; n_ev = 0; first_ev = -1; last_ev = -1;
    for (int c = 0; c < 12; c++) begin
      if (bus.in_valid && bus.in_ready) accepted = 1'b1;
      @(negedge clk);
      if (bus.exec_valid) begin
        n_ev++;
        if (first_ev < 0) first_ev = c;
        last_ev = c;
      end
      tick(!accepted, full_set[4], 1'b1, 2'(c));
    end
    check("full_fifth_accepted", 32'(accepted), 32'd1);
    check("full_issue_count", 32'(n_ev), 32'd5);
    check("full_issue_contig", 32'(last_ev - first_ev + 1), 32'd5);

    // Run drop while an instruction is in exec.
    do_reset();
    tick(1'b1, 9'h006, 1'b1, 2'd0);
    tick(1'b1, 9'h0D9, 1'b1, 2'd0);
    tick(1'b0, 9'd0, 1'b0, 2'd0);
    @(negedge clk);
    check("rundrop_inflight", 32'(bus.exec_valid), 32'd1);
    tick(1'b0, 9'd0, 1'b0, 2'd0);
    @(negedge clk);
    check("rundrop_retired", 32'(retired), 32'd1);
    check("rundrop_r0", 32'(dbg_data), 32'd5);
    check("rundrop_stall", 32'(bus.exec_valid), 32'd0);
    tick(1'b0, 9'd0, 1'b0, 2'd0);
    tick(1'b0, 9'd0, 1'b0, 2'd0);
    @(negedge clk);
    check("rundrop_stall2", 32'(bus.exec_valid), 32'd0);
    tick(1'b0, 9'd0, 1'b1, 2'd0);
    tick(1'b0, 9'd0, 1'b1, 2'd0);
    @(negedge clk);
    check("rundrop_resume", 32'(bus.exec_valid), 32'd1);
    tick(1'b0, 9'd0, 1'b1, 2'd0);
    @(negedge clk);
    check("rundrop_retired2", 32'(retired), 32'd2);

    // Reset mid-operation: 3 queued, one in exec.
    do_reset();
    tick(1'b1, 9'h006, 1'b0, 2'd0);
    tick(1'b1, 9'h016, 1'b0, 2'd0);
    tick(1'b1, 9'h026, 1'b0, 2'd0);
    tick(1'b1, 9'h036, 1'b0, 2'd0);
    tick(1'b0, 9'd0, 1'b1, 2'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("midrst_pre_valid", 32'(bus.exec_valid), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_valid", 32'(bus.exec_valid), 32'd0);
    check("midrst_retired", 32'(retired), 32'd0);
    check("midrst_r0", 32'(dbg_data), 32'd1);
    for (int a = 1; a < 4; a++) begin
      tick(1'b0, 9'd0, 1'b1, 2'(a));
      @(negedge clk);
      check("midrst_reg", 32'(dbg_data), 32'(a + 1));
      check("midrst_empty", 32'(bus.exec_valid), 32'd0);
    end

    // Retired counter wrap over 256 OR instructions.
    do_reset();
    pushed = 0; cyc = 0;
    r6 = 6'($urandom_range(0, 63));
    ins = {3'd3, r6};
    while (pushed < 256 && cyc < 3000) begin
      tick(1'b1, ins, 1'b1, 2'($urandom_range(0, 3)));
      if (bus.in_ready) begin
        pushed++;
        r6 = 6'($urandom_range(0, 63));
        ins = {3'd3, r6};
      end
      cyc++;
    end
    check("wrap_pushed", 32'(pushed), 32'd256);
    repeat (4) tick(1'b0, 9'd0, 1'b1, 2'd0);
    @(negedge clk);
    check("wrap_retired", 32'(retired), 32'd0);
    check("wrap_model", 32'(m_retired), 32'd0);

    // Randomized traffic with occasional resets.
    do_reset();
    for (int c = 0; c < 2000; c++) begin
      @(posedge clk); #1;
      rst          = ($urandom_range(0, 99) == 0);
      bus.in_valid = ($urandom_range(0, 3) != 0);
      bus.in_instr = 9'($urandom_range(0, 511));
      run          = ($urandom_range(0, 4) != 0);
      dbg_addr     = 2'($urandom_range(0, 3));
    end
    @(posedge clk); #1;
    rst = 1'b0; bus.in_valid = 1'b0; run = 1'b1;
    repeat (8) @(posedge clk);
    @(negedge clk);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
